// File: rtl/fetch_pkg.sv
// Shared fetch definitions: address/instruction widths and the
// fetch sequencer state encoding, used by fetch_ctrl and decode.
package fetch_pkg;

    localparam int FETCH_AW = 10;
    localparam int FETCH_IW = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the zero-wait
// instruction memory and presents one registered instruction to decode.
// Ports: clk, rst_n (async, active low); start, redirect/redirect_pc,
// halt control; im_addr/im_in memory read; instr/instr_pc/instr_valid/
// instr_ready decode handshake; busy, done, pc_wrap status.
import fetch_pkg::*;

module fetch_ctrl #(
    parameter int            AW       = FETCH_AW,
    parameter int            IW       = FETCH_IW,
    parameter logic [AW-1:0] START_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] im_addr,
    input  logic [IW-1:0] im_in,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic          busy,
    output logic          done,
    output logic          pc_wrap
);

    localparam logic [AW-1:0] ONE = AW'(1);

    fetch_state_t  state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic [IW-1:0] instr_n;
    logic [AW-1:0] instr_pc_n;
    logic          valid_n;
    logic          wrap_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= START_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            pc_wrap     <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            instr_valid <= valid_n;
            pc_wrap     <= wrap_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        instr_n    = instr;
        instr_pc_n = instr_pc;
        valid_n    = instr_valid;
        wrap_n     = pc_wrap;
        unique case (state)
            IDLE, HALTED: begin
                valid_n = 1'b0;
                if (start) begin
                    pc_n    = START_PC;
                    wrap_n  = 1'b0;
                    state_n = RUN;
                end
            end
            RUN: begin
                // Halt beats redirect: the PC stays at the halt point.
                if (halt) begin
                    valid_n = 1'b0;
                    state_n = HALTED;
                end else if (redirect) begin
                    pc_n    = redirect_pc;
                    valid_n = 1'b0;
                end else if (!instr_valid || instr_ready) begin
                    instr_n    = im_in;
                    instr_pc_n = pc;
                    valid_n    = 1'b1;
                    pc_n       = pc + ONE;
                    if (pc == '1) begin
                        wrap_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    assign im_addr = pc;
    assign busy    = (state == RUN);
    assign done    = (state == HALTED);

endmodule
